// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: pipe-register write enables, load-use stall,
// data-memory wait freeze with timeout, and exception entry sequencing.
//
// Ports:
//   clk, reset (async, active-low)
//   ex_mem_read, ex_rd_load[2:0] : load in ID/EX and its destination
//   id_src[11:0], id_src_vld[3:0]: four ID-pair sources {s3,s2,s1,s0}
//   branch_taken                 : branch resolved taken this cycle
//   ex_cause, ex_invalid         : ID/EX exception sources
//   mem_busy                     : data memory not ready
//   pc_write, if_write, id_write,
//   ex_mem_write, mem_wb_write   : pipe register write enables
//   if_id_flush, id_ex_bubble    : IF/ID clear, ID/EX control squash
//   pc_sel[1:0]                  : 0 seq, 1 branch, 2 exception vector
//   epc_write                    : capture ID/EX pc into EPC
//   exc_code[2:0]                : {timeout,invalid,cause}, sticky
//   stall_cnt[31:0], flush_cnt[15:0] : perf counters
//
// Build option: define PIPE_CTRL_PERF_EN to enable the perf counters;
// otherwise both counter ports are tied to zero.

module pipeline_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES    = 2,
  parameter int unsigned MEM_TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mem_read,
  input  logic [2:0]  ex_rd_load,
  input  logic [11:0] id_src,
  input  logic [3:0]  id_src_vld,
  input  logic        branch_taken,
  input  logic        ex_cause,
  input  logic        ex_invalid,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_write,
  output logic        if_id_flush,
  output logic        id_write,
  output logic        id_ex_bubble,
  output logic        ex_mem_write,
  output logic        mem_wb_write,
  output logic [1:0]  pc_sel,
  output logic        epc_write,
  output logic [2:0]  exc_code,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [2:0] {
    RUN,
    LU_STALL,
    MEM_WAIT,
    EXC_DRAIN,
    EXC_VEC
  } state_e;

  localparam logic [7:0] DRAIN_C = 8'(DRAIN_CYCLES);
  localparam logic [7:0] TMO_C   = 8'(MEM_TIMEOUT);
  localparam logic [1:0] LU_M1   = 2'(LU_STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lu_q, lu_d;
  logic       from_lu_q, from_lu_d;
  logic [2:0] exc_q, exc_d;

  logic       src_hit;
  logic       hazard;
  logic       exc_in;

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (id_src_vld[i] && (id_src[3*i +: 3] == ex_rd_load)) begin
        src_hit = 1'b1;
      end
    end
  end

  assign hazard = ex_mem_read & src_hit;
  assign exc_in = ex_cause | ex_invalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      lu_q      <= '0;
      from_lu_q <= 1'b0;
      exc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lu_q      <= lu_d;
      from_lu_q <= from_lu_d;
      exc_q     <= exc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lu_d         = lu_q;
    from_lu_d    = from_lu_q;
    exc_d        = exc_q;
    pc_write     = 1'b1;
    if_write     = 1'b1;
    id_write     = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_sel       = 2'd0;
    epc_write    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (exc_in) begin
          epc_write    = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          pc_write     = 1'b0;
          exc_d        = {1'b0, ex_invalid, ex_cause};
          cnt_d        = DRAIN_C;
          state_d      = EXC_DRAIN;
        end else if (mem_busy) begin
          pc_write     = 1'b0;
          if_write     = 1'b0;
          id_write     = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
          cnt_d        = 8'd1;
          from_lu_d    = 1'b0;
          state_d      = MEM_WAIT;
        end else if (branch_taken) begin
          pc_sel       = 2'd1;
          if_id_flush  = 1'b1;
        end else if (hazard) begin
          pc_write     = 1'b0;
          if_write     = 1'b0;
          id_ex_bubble = 1'b1;
          if (LU_M1 != 2'd0) begin
            lu_d    = LU_M1;
            state_d = LU_STALL;
          end
        end
      end

      LU_STALL: begin
        if (mem_busy) begin
          // Remaining stall count is kept in lu_q across the wait.
          pc_write     = 1'b0;
          if_write     = 1'b0;
          id_write     = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
          cnt_d        = 8'd1;
          from_lu_d    = 1'b1;
          state_d      = MEM_WAIT;
        end else begin
          pc_write     = 1'b0;
          if_write     = 1'b0;
          id_ex_bubble = 1'b1;
          if (lu_q <= 2'd1) begin
            lu_d    = 2'd0;
            state_d = RUN;
          end else begin
            lu_d = lu_q - 2'd1;
          end
        end
      end

      MEM_WAIT: begin
        if (mem_busy) begin
          if (cnt_q == TMO_C) begin
            // Bus error: memory still busy, so EX/MEM and MEM/WB hold.
            pc_write     = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            exc_d        = 3'b100;
            cnt_d        = DRAIN_C;
            from_lu_d    = 1'b0;
            lu_d         = 2'd0;
            state_d      = EXC_DRAIN;
          end else begin
            pc_write     = 1'b0;
            if_write     = 1'b0;
            id_write     = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if (cnt_q != 8'hFF) begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end else if (from_lu_q) begin
          // Load-use still pending: hold PC/IF while returning.
          pc_write     = 1'b0;
          if_write     = 1'b0;
          id_ex_bubble = 1'b1;
          from_lu_d    = 1'b0;
          state_d      = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end

      EXC_DRAIN: begin
        pc_write     = 1'b0;
        if_write     = 1'b0;
        id_ex_bubble = 1'b1;
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = EXC_VEC;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      EXC_VEC: begin
        pc_sel       = 2'd2;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign exc_code = exc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (if_id_flush && (flush_q != '1)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-value
// queue; outputs sampled on the negedge, inputs driven after posedge.

module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_read;
  logic [2:0]  ex_rd_load;
  logic [11:0] id_src;
  logic [3:0]  id_src_vld;
  logic        branch_taken;
  logic        ex_cause;
  logic        ex_invalid;
  logic        mem_busy;
  logic        pc_write;
  logic        if_write;
  logic        if_id_flush;
  logic        id_write;
  logic        id_ex_bubble;
  logic        ex_mem_write;
  logic        mem_wb_write;
  logic [1:0]  pc_sel;
  logic        epc_write;
  logic [2:0]  exc_code;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .LU_STALL_CYCLES(1),
    .DRAIN_CYCLES(2),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ex_mem_read(ex_mem_read),
    .ex_rd_load(ex_rd_load),
    .id_src(id_src),
    .id_src_vld(id_src_vld),
    .branch_taken(branch_taken),
    .ex_cause(ex_cause),
    .ex_invalid(ex_invalid),
    .mem_busy(mem_busy),
    .pc_write(pc_write),
    .if_write(if_write),
    .if_id_flush(if_id_flush),
    .id_write(id_write),
    .id_ex_bubble(id_ex_bubble),
    .ex_mem_write(ex_mem_write),
    .mem_wb_write(mem_wb_write),
    .pc_sel(pc_sel),
    .epc_write(epc_write),
    .exc_code(exc_code),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // {pc,if,flush,id,bubble,exmem,memwb,pc_sel[1:0],epc}
  localparam logic [9:0] IDLE   = 10'b1101011000;
  localparam logic [9:0] FREEZE = 10'b0000000000;
  localparam logic [9:0] STALL  = 10'b0001111000;
  localparam logic [9:0] BRANCH = 10'b1111011010;
  localparam logic [9:0] EXC    = 10'b0111111001;
  localparam logic [9:0] DRAIN  = 10'b0001111000;
  localparam logic [9:0] VEC    = 10'b1111111100;
  localparam logic [9:0] TMO    = 10'b0111100000;

  typedef struct packed {
    logic [9:0] ctl;
    logic [2:0] code;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  wire [9:0] ctl_obs = {pc_write, if_write, if_id_flush, id_write,
                        id_ex_bubble, ex_mem_write, mem_wb_write,
                        pc_sel, epc_write};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ex_mem_read  = 1'b0;
    ex_rd_load   = 3'd0;
    id_src       = 12'd0;
    id_src_vld   = 4'd0;
    branch_taken = 1'b0;
    ex_cause     = 1'b0;
    ex_invalid   = 1'b0;
    mem_busy     = 1'b0;
  endtask

  task automatic step(input string tag, input logic [9:0] ctl,
                      input logic [2:0] code);
    exp_t e;
    sb.push_back('{ctl: ctl, code: code});
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".ctl"}, 32'(ctl_obs), 32'(e.ctl));
      chk({tag, ".code"}, 32'(exc_code), 32'(e.code));
`ifdef PIPE_CTRL_PERF_EN
      chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
      chk({tag, ".flush_cnt"}, 32'(flush_cnt), m_flush);
      if (!e.ctl[9]) m_stall++;
      if (e.ctl[7]) m_flush++;
`else
      chk({tag, ".stall_cnt"}, stall_cnt, 32'd0);
      chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'd0);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    step("in_reset", IDLE, 3'b000);
    reset = 1'b1;
    step("idle", IDLE, 3'b000);

    // load-use on s1
    ex_mem_read = 1'b1;
    ex_rd_load  = 3'd3;
    id_src      = {3'd0, 3'd0, 3'd3, 3'd0};
    id_src_vld  = 4'b0010;
    step("lu_s1", STALL, 3'b000);
    idle_in();
    step("lu_done", IDLE, 3'b000);

    // match exists but its valid bit is clear
    ex_mem_read = 1'b1;
    ex_rd_load  = 3'd3;
    id_src      = {3'd0, 3'd0, 3'd3, 3'd0};
    id_src_vld  = 4'b0001;
    step("lu_novld", IDLE, 3'b000);

    // match on s3 but not a load
    ex_mem_read = 1'b0;
    id_src      = {3'd3, 3'd0, 3'd0, 3'd0};
    id_src_vld  = 4'b1000;
    step("lu_noload", IDLE, 3'b000);
    ex_mem_read = 1'b1;
    step("lu_s3", STALL, 3'b000);

    // branch beats hazard
    branch_taken = 1'b1;
    step("br_haz", BRANCH, 3'b000);
    idle_in();
    step("br_done", IDLE, 3'b000);

    // invalid opcode exception
    ex_invalid = 1'b1;
    step("exc", EXC, 3'b000);
    ex_invalid   = 1'b0;
    ex_cause     = 1'b1;
    branch_taken = 1'b1;
    step("drain1_ign", DRAIN, 3'b010);
    idle_in();
    step("drain2", DRAIN, 3'b010);
    step("vec", VEC, 3'b010);
    step("exc_run", IDLE, 3'b010);

    // short memory wait
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) step("mw5", FREEZE, 3'b010);
    mem_busy = 1'b0;
    step("mw5_done", IDLE, 3'b010);
    step("mw5_run", IDLE, 3'b010);

    // memory timeout
    mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) step("mw_frz", FREEZE, 3'b010);
    step("mw_tmo", TMO, 3'b010);
    step("tmo_dr1", DRAIN, 3'b100);
    step("tmo_dr2", DRAIN, 3'b100);
    step("tmo_vec", VEC, 3'b100);
    step("tmo_busy", FREEZE, 3'b100);
    mem_busy = 1'b0;
    step("tmo_done", IDLE, 3'b100);

    // exception outranks mem_busy and branch; reset mid-drain
    ex_cause     = 1'b1;
    ex_invalid   = 1'b1;
    mem_busy     = 1'b1;
    branch_taken = 1'b1;
    step("exc_prio", EXC, 3'b100);
    idle_in();
    step("prio_dr1", DRAIN, 3'b011);
    reset = 1'b0;
    #1;
    chk("rst_async.ctl", 32'(ctl_obs), 32'(IDLE));
    chk("rst_async.code", 32'(exc_code), 32'd0);
    chk("rst_async.flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_async.stall_cnt", stall_cnt, 32'd0);
    m_stall = 0;
    m_flush = 0;
    @(posedge clk);
    #1;
    step("rst_hold", IDLE, 3'b000);
    reset = 1'b1;
    step("rst_run", IDLE, 3'b000);
    step("rst_run2", IDLE, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
